// File: rtl/bam_seq_mul_ctrl.sv
// bam_seq_mul_ctrl: sequential broken-array (BAM) approximate multiplier.
// Accumulates one kept partial-product row per cycle into a 2N-bit
// accumulator, with rows below H and product columns below V discarded.
// Optional feature macro: BAM_SKIP_ZERO_EN (early termination once the
// remaining multiplier bits are all zero; the result is unchanged).
module bam_seq_mul_ctrl #(
    parameter int N = 8,
    parameter int H = 3,
    parameter int V = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    localparam int PW = 2 * N;
    localparam int JW = $clog2(N + 1);

    // Product columns 0..V-1 are cleared from every row.
    localparam logic [PW-1:0] COLMASK = {PW{1'b1}} << V;
    localparam logic [JW-1:0] J_FIRST = JW'(H);
    localparam logic [JW-1:0] J_LAST  = JW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [JW-1:0]  j_q, j_d;
    logic [PW-1:0]  acc_q, acc_d;

    logic           row_bit_s;
    logic [PW-1:0]  row_s;

    // Current row: multiplier bit j selects the shifted, column-masked multiplicand.
    always_comb begin
        row_bit_s = |(b_q & ({{(N-1){1'b0}}, 1'b1} << j_q));
        row_s     = row_bit_s ? ((({{N{1'b0}}, a_q}) << j_q) & COLMASK)
                              : {PW{1'b0}};
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {N{1'b0}};
            b_q     <= {N{1'b0}};
            j_q     <= {JW{1'b0}};
            acc_q   <= {PW{1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        j_d     = j_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    j_d   = J_FIRST;
                    acc_d = {PW{1'b0}};
                    if (H >= N) begin
                        // No rows are kept: the product is zero immediately.
                        state_d = DONE;
`ifdef BAM_SKIP_ZERO_EN
                    end else if ((b >> H) == {N{1'b0}}) begin
                        // Every kept multiplier bit is zero.
                        state_d = DONE;
`endif
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_q + row_s;
                j_d   = j_q + {{(JW-1){1'b0}}, 1'b1};
                if (j_q == J_LAST) begin
                    state_d = DONE;
`ifdef BAM_SKIP_ZERO_EN
                end else if (((b_q >> j_q) >> 1) == {N{1'b0}}) begin
                    // Remaining rows above j contribute nothing.
                    state_d = DONE;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and result outputs decoded from registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        p         = acc_q;
    end

endmodule

// File: tb/tb_bam_seq_mul_ctrl.sv
// tb_bam_seq_mul_ctrl: directed table, multi-cycle corner sequences and a
// random sweep against a reference BAM sum. Unit 0 uses the default
// parameters (N=8, H=3, V=10); unit 1 uses H=0, V=0 (exact product).
module tb_bam_seq_mul_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid_v  [2];
    logic        in_ready_v  [2];
    logic [7:0]  a_v         [2];
    logic [7:0]  b_v         [2];
    logic        out_valid_v [2];
    logic        out_ready_v [2];
    logic [15:0] p_v         [2];
    logic        busy_v      [2];

    int n_chk  = 0;
    int n_fail = 0;

    bam_seq_mul_ctrl #(.N(8), .H(3), .V(10)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .a         (a_v[0]),
        .b         (b_v[0]),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .p         (p_v[0]),
        .busy      (busy_v[0])
    );

    bam_seq_mul_ctrl #(.N(8), .H(0), .V(0)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .a         (a_v[1]),
        .b         (b_v[1]),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .p         (p_v[1]),
        .busy      (busy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat_fix;
        int          lat_skip;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference BAM sum built bit by bit from the arithmetic definition.
    function automatic logic [15:0] bam_ref(input logic [7:0] a, input logic [7:0] b,
                                            input int h, input int v);
        logic [15:0] r;
        logic [7:0]  ai;
        logic [7:0]  bj;
        r = 16'd0;
        for (int j = h; j < 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                ai = a >> i;
                bj = b >> j;
                if ((i + j >= v) && ai[0] && bj[0]) begin
                    r = r + (16'd1 << (i + j));
                end
            end
        end
        return r;
    endfunction

    // Edges after the accepting edge until out_valid is seen high.
    function automatic int lat_ref(input logic [7:0] b, input int h);
`ifdef BAM_SKIP_ZERO_EN
        int m;
        logic [7:0] bk;
        m = -1;
        for (int k = h; k < 8; k++) begin
            bk = b >> k;
            if (bk[0]) m = k;
        end
        return (m < h) ? 0 : (m - h + 1);
`else
        return 8 - h;
`endif
    endfunction

    // One full transaction on unit u: accept, wait for result, optional stall, take.
    task automatic do_op(input int u, input logic [7:0] a, input logic [7:0] b,
                         input int stall, output logic [15:0] pr, output int lat,
                         output int bad);
        int w;
        w   = 0;
        bad = 0;
        while (!in_ready_v[u] && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_wait", 32'(in_ready_v[u]), 32'd1);
        a_v[u]        = a;
        b_v[u]        = b;
        in_valid_v[u] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[u] = 1'b0;
        a_v[u]        = 8'($urandom);
        b_v[u]        = 8'($urandom);
        lat = 0;
        while (!out_valid_v[u] && lat < 40) begin
            if (in_ready_v[u] || !busy_v[u]) bad++;
            @(posedge clk); #1; lat++;
        end
        chk("out_valid_timeout", 32'(out_valid_v[u]), 32'd1);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
        end
        pr = p_v[u];
        out_ready_v[u] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[u] = 1'b0;
    endtask

    initial begin
        logic [15:0] pr;
        logic [15:0] exp_p;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          lat;
        int          bad;
        int          exp_lat;
        int          cnt;

        vecs[0] = '{8'd255, 8'd255, 16'hE400, 5, 5};
        vecs[1] = '{8'd128, 8'd8,   16'h0400, 5, 1};
        vecs[2] = '{8'd5,   8'd200, 16'h0000, 5, 5};
        vecs[3] = '{8'd255, 8'd7,   16'h0000, 5, 0};
        vecs[4] = '{8'd0,   8'd0,   16'h0000, 5, 0};
        vecs[5] = '{8'd255, 8'd128, 16'h7C00, 5, 5};
        vecs[6] = '{8'd1,   8'd255, 16'h0000, 5, 5};
        vecs[7] = '{8'd128, 8'd128, 16'h4000, 5, 5};
        vecs[8] = '{8'd170, 8'd16,  16'h0800, 5, 2};

        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_valid_v[u]  = 1'b0;
            out_ready_v[u] = 1'b0;
            a_v[u]         = 8'd0;
            b_v[u]         = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            chk("reset_in_ready",  32'(in_ready_v[u]),  32'd1);
            chk("reset_out_valid", 32'(out_valid_v[u]), 32'd0);
            chk("reset_busy",      32'(busy_v[u]),      32'd0);
            chk("reset_p",         32'(p_v[u]),         32'd0);
        end

        // Directed table on the default-parameter unit.
        for (int k = 0; k < 9; k++) begin
            do_op(0, vecs[k].a, vecs[k].b, 0, pr, lat, bad);
`ifdef BAM_SKIP_ZERO_EN
            exp_lat = vecs[k].lat_skip;
`else
            exp_lat = vecs[k].lat_fix;
`endif
            chk("vec_p",        32'(pr),  32'(vecs[k].p));
            chk("vec_latency",  32'(lat), 32'(exp_lat));
            chk("vec_busy_run", 32'(bad), 32'd0);
        end

        // Result held in DONE while the consumer stalls; offers are ignored.
        a_v[0] = 8'd255; b_v[0] = 8'd255; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        cnt = 0;
        while (!out_valid_v[0] && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid_v[0] = (c % 2 == 0);
            a_v[0] = 8'd1; b_v[0] = 8'd255;
            @(posedge clk); #1;
            if (!out_valid_v[0] || in_ready_v[0] || p_v[0] !== 16'hE400) bad++;
        end
        in_valid_v[0] = 1'b0;
        chk("done_hold_p",   32'(p_v[0]), 32'h0000E400);
        chk("done_hold_bad", 32'(bad),    32'd0);
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        chk("after_take_in_ready",  32'(in_ready_v[0]),  32'd1);
        chk("after_take_out_valid", 32'(out_valid_v[0]), 32'd0);
        do_op(0, 8'd128, 8'd8, 0, pr, lat, bad);
        chk("after_hold_p",   32'(pr),  32'h00000400);
        chk("after_hold_lat", 32'(lat), 32'(lat_ref(8'd8, 3)));

        // Reset asserted on the third RUN edge discards the operation.
        a_v[0] = 8'd255; b_v[0] = 8'd255; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready",  32'(in_ready_v[0]),  32'd1);
        chk("midrst_busy",      32'(busy_v[0]),      32'd0);
        chk("midrst_p",         32'(p_v[0]),         32'd0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid_v[0]) bad++;
            @(posedge clk); #1;
        end
        chk("midrst_no_out_valid", 32'(bad), 32'd0);
        do_op(0, 8'd128, 8'd8, 0, pr, lat, bad);
        chk("midrst_next_p", 32'(pr), 32'h00000400);

        // Random sweep with consumer stalls on both parameter sets.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 8'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
                do_op(u, ra, rb, $urandom_range(0, 3), pr, lat, bad);
                exp_p = (u == 0) ? bam_ref(ra, rb, 3, 10) : bam_ref(ra, rb, 0, 0);
                chk("rand_p",   32'(pr),  32'(exp_p));
                chk("rand_lat", 32'(lat), 32'(lat_ref(rb, (u == 0) ? 3 : 0)));
                if (u == 1) begin
                    chk("rand_exact", 32'(pr), 32'(16'(ra) * 16'(rb)));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
